// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key_mode encodings, Nk/Nr lookup,
// FSM state type and the GF(2^8) doubling used by Rcon and the S-box.
package aes_pkg;

  localparam logic [1:0] KEY_MODE_128 = 2'b00;
  localparam logic [1:0] KEY_MODE_192 = 2'b01;
  localparam logic [1:0] KEY_MODE_256 = 2'b10;
  localparam logic [1:0] KEY_MODE_BAD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      KEY_MODE_128: return 4'd4;
      KEY_MODE_192: return 4'd6;
      default:      return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      KEY_MODE_128: return 4'd10;
      KEY_MODE_192: return 4'd12;
      default:      return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (x^254) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  assign dout = affine(gf_inv(din));

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expander, one schedule word per cycle, with
// synchronous round-key read port. Optional macro AES_KEY_EXP_ZEROIZE_EN adds
// a zeroize input that wipes the stored schedule.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_W = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           key_mode,
  input  logic [MAX_KEY_W-1:0] key_i,
`ifdef AES_KEY_EXP_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic                 rd_en,
  input  logic [3:0]           rd_idx,
  output logic                 ready,
  output logic                 done,
  output logic                 key_valid,
  output logic                 mode_err,
  output logic [127:0]         rd_data,
  output logic                 rd_vld,
  output logic                 rd_err
);

  localparam int NK_MAX = MAX_KEY_W / 32;
  localparam int WORDS  = 4 * (NK_MAX + 7);

  logic [31:0] w [WORDS];

  state_t      state, state_nx;
  logic [1:0]  mode;
  logic [5:0]  idx;
  logic [2:0]  phase;
  logic [7:0]  rcon;

  logic [3:0]  nk, nr, start_nk;
  logic [5:0]  last_idx, prev_idx, back_idx;
  logic        mode_ok, accept, reject, wipe, last_word;
  logic [31:0] prev, back, sub_in, sub_out, temp, nxt_word;

`ifdef AES_KEY_EXP_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  assign nk        = nk_of(mode);
  assign nr        = nr_of(mode);
  assign start_nk  = nk_of(key_mode);
  assign last_idx  = {nr, 2'b11};
  assign prev_idx  = idx - 6'd1;
  assign back_idx  = idx - {2'b00, nk};
  assign last_word = (state == EXPAND) && (idx == last_idx);

  assign mode_ok = (key_mode != KEY_MODE_BAD) && ((int'(start_nk) * 32) <= MAX_KEY_W);
  assign accept  = start && (state == IDLE) && mode_ok && !wipe;
  assign reject  = start && (state == IDLE) && !mode_ok && !wipe;

  // phase tracks i mod Nk so the word rule needs no divider
  always_comb begin
    prev     = w[prev_idx];
    back     = w[back_idx];
    sub_in   = (phase == 3'd0) ? {prev[7:0], prev[31:8]} : prev;
    temp     = prev;
    if (phase == 3'd0) begin
      temp = sub_out ^ {24'h0, rcon};
    end else if ((nk == 4'd8) && (phase == 3'd4)) begin
      temp = sub_out;
    end
    nxt_word = back ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    state_nx = state;
    ready    = (state == IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nx = EXPAND;
      EXPAND:  if (last_word) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (wipe) state_nx = IDLE;
  end

  // Schedule storage: no reset, key_valid guards its contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wipe) begin
        for (int k = 0; k < WORDS; k++) w[k] <= '0;
      end else if (accept) begin
        for (int k = 0; k < NK_MAX; k++) begin
          if (k < int'(start_nk)) w[k] <= key_i[32*k +: 32];
        end
      end else if (state == EXPAND) begin
        w[idx] <= nxt_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= KEY_MODE_128;
      idx       <= '0;
      phase     <= '0;
      rcon      <= RCON_INIT;
      key_valid <= 1'b0;
      mode_err  <= 1'b0;
      rd_vld    <= 1'b0;
      rd_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      state    <= state_nx;
      mode_err <= reject;
      rd_vld   <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      if (rd_en) begin
        if (key_valid && (rd_idx <= nr)) begin
          rd_vld  <= 1'b1;
          rd_data <= {w[{rd_idx, 2'd3}], w[{rd_idx, 2'd2}], w[{rd_idx, 2'd1}], w[{rd_idx, 2'd0}]};
        end else begin
          rd_err <= 1'b1;
        end
      end
      if (wipe) begin
        key_valid <= 1'b0;
      end else if (accept) begin
        mode      <= key_mode;
        key_valid <= 1'b0;
        idx       <= 6'(start_nk);
        phase     <= '0;
        rcon      <= RCON_INIT;
      end else if (state == EXPAND) begin
        idx   <= idx + 6'd1;
        phase <= ({1'b0, phase} == (nk - 4'd1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
        if (last_word) key_valid <= 1'b1;
      end
    end
  end

endmodule
